// File: rtl/combat_controller.sv
// combat_controller: hit points, damage, shot cooldown and death flags.
// Define COMBAT_INVULN_EN for tick-based invulnerability windows instead of edge-only hits.
module combat_controller #(
    parameter int HP_W          = 7,
    parameter int MAX_HP        = 100,
    parameter int HIT_DAMAGE    = 10,
    parameter int SHOT_COOLDOWN = 30,
    parameter int INVULN_FRAMES = 20
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            frame_clk,
    input  logic            game_active,
    input  logic            Shoot_req,
    input  logic            Proj_hit_npc,
    input  logic            Npc_hit_player,
    output logic            Shoot_fire,
    output logic            shot_ready,
    output logic [HP_W-1:0] Player_HP,
    output logic [HP_W-1:0] NPC_HP,
    output logic            Player_Dead,
    output logic            NPC_Dead
);

    localparam logic [HP_W-1:0] HP_MAX = HP_W'(MAX_HP);
    localparam logic [HP_W-1:0] DMG    = HP_W'(HIT_DAMAGE);
    localparam logic [7:0]      COOL   = 8'(SHOT_COOLDOWN);

    if (MAX_HP >= (1 << HP_W) || MAX_HP < 1 ||
        SHOT_COOLDOWN < 1 || SHOT_COOLDOWN > 255 ||
        INVULN_FRAMES < 1 || INVULN_FRAMES > 255) begin : g_bad_param
        $error("combat_controller: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ARMED, COOLDOWN, OVER} state_t;

    state_t          state_q, state_d;
    logic            fs_meta_q, fs_meta_d;
    logic            fs_sync_q, fs_sync_d;
    logic            fs_prev_q, fs_prev_d;
    logic            shoot_prev_q, shoot_prev_d;
    logic            fire_q, fire_d;
    logic [7:0]      cool_q, cool_d;
    logic [HP_W-1:0] php_q, php_d;
    logic [HP_W-1:0] nhp_q, nhp_d;
    logic            pdead_q, pdead_d;
    logic            ndead_q, ndead_d;

    logic tick;
    logic shoot_edge;
    logic in_play;
    logic p_acc;
    logic n_acc;

    function automatic logic [HP_W-1:0] apply_dmg(input logic [HP_W-1:0] hp);
        return (hp > DMG) ? hp - DMG : '0;
    endfunction

    assign tick       = fs_sync_q & ~fs_prev_q;
    assign shoot_edge = Shoot_req & ~shoot_prev_q;
    // Damage stops the moment either side is out, so a kill freezes both counters.
    assign in_play    = game_active && (state_q == ARMED || state_q == COOLDOWN) &&
                        (php_q != '0) && (nhp_q != '0);

`ifdef COMBAT_INVULN_EN
    localparam logic [7:0] INV = 8'(INVULN_FRAMES);

    logic [7:0] pinv_q, pinv_d;
    logic [7:0] ninv_q, ninv_d;

    assign p_acc = in_play && Npc_hit_player && (pinv_q == '0);
    assign n_acc = in_play && Proj_hit_npc && (ninv_q == '0);

    always_comb begin
        pinv_d = pinv_q;
        ninv_d = ninv_q;
        if (state_q == IDLE) begin
            pinv_d = '0;
            ninv_d = '0;
        end else begin
            if (p_acc)
                pinv_d = INV;
            else if (tick && pinv_q != '0)
                pinv_d = pinv_q - 8'd1;
            if (n_acc)
                ninv_d = INV;
            else if (tick && ninv_q != '0)
                ninv_d = ninv_q - 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pinv_q <= '0;
            ninv_q <= '0;
        end else begin
            pinv_q <= pinv_d;
            ninv_q <= ninv_d;
        end
    end
`else
    logic phit_prev_q, phit_prev_d;
    logic nhit_prev_q, nhit_prev_d;

    assign phit_prev_d = Npc_hit_player;
    assign nhit_prev_d = Proj_hit_npc;
    assign p_acc = in_play && Npc_hit_player && !phit_prev_q;
    assign n_acc = in_play && Proj_hit_npc && !nhit_prev_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            phit_prev_q <= 1'b0;
            nhit_prev_q <= 1'b0;
        end else begin
            phit_prev_q <= phit_prev_d;
            nhit_prev_q <= nhit_prev_d;
        end
    end
`endif

    always_comb begin
        fs_meta_d    = frame_clk;
        fs_sync_d    = fs_meta_q;
        fs_prev_d    = fs_sync_q;
        shoot_prev_d = Shoot_req;
        state_d      = state_q;
        fire_d       = 1'b0;
        cool_d       = cool_q;
        php_d        = php_q;
        nhp_d        = nhp_q;
        pdead_d      = game_active && (php_q == '0);
        ndead_d      = game_active && (nhp_q == '0);

        if (p_acc)
            php_d = apply_dmg(php_q);
        if (n_acc)
            nhp_d = apply_dmg(nhp_q);
        if (state_q == IDLE) begin
            php_d = HP_MAX;
            nhp_d = HP_MAX;
        end

        if (!game_active) begin
            state_d = IDLE;
            cool_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = ARMED;
                ARMED: begin
                    if (php_q == '0 || nhp_q == '0) begin
                        state_d = OVER;
                    end else if (shoot_edge) begin
                        fire_d  = 1'b1;
                        cool_d  = COOL;
                        state_d = COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    if (php_q == '0 || nhp_q == '0) begin
                        state_d = OVER;
                    end else if (tick) begin
                        cool_d = cool_q - 8'd1;
                        if (cool_q <= 8'd1) begin
                            cool_d  = '0;
                            state_d = ARMED;
                        end
                    end
                end
                OVER: state_d = OVER;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            fs_meta_q    <= 1'b0;
            fs_sync_q    <= 1'b0;
            fs_prev_q    <= 1'b0;
            shoot_prev_q <= 1'b0;
            fire_q       <= 1'b0;
            cool_q       <= '0;
            php_q        <= HP_MAX;
            nhp_q        <= HP_MAX;
            pdead_q      <= 1'b0;
            ndead_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fs_meta_q    <= fs_meta_d;
            fs_sync_q    <= fs_sync_d;
            fs_prev_q    <= fs_prev_d;
            shoot_prev_q <= shoot_prev_d;
            fire_q       <= fire_d;
            cool_q       <= cool_d;
            php_q        <= php_d;
            nhp_q        <= nhp_d;
            pdead_q      <= pdead_d;
            ndead_q      <= ndead_d;
        end
    end

    assign Shoot_fire  = fire_q;
    assign shot_ready  = (state_q == ARMED) && game_active;
    assign Player_HP   = php_q;
    assign NPC_HP      = nhp_q;
    assign Player_Dead = pdead_q;
    assign NPC_Dead    = ndead_q;

endmodule

// File: tb/tb_combat_controller.sv
// Scoreboard bench for combat_controller: default unit plus a MAX_HP=15 unit.
// Expected fires and status snapshots are queued by stimulus and checked by a monitor.
module tb_combat_controller;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       game_active = 1'b0;
    logic       Shoot_req = 1'b0;
    logic       Proj_hit_npc = 1'b0;
    logic       Npc_hit_player = 1'b0;
    logic       fire, ready, pdead, ndead;
    logic [6:0] php, nhp;
    logic       fire2, ready2, pdead2, ndead2;
    logic [6:0] php2, nhp2;

    combat_controller u_dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .game_active(game_active), .Shoot_req(Shoot_req),
        .Proj_hit_npc(Proj_hit_npc), .Npc_hit_player(Npc_hit_player),
        .Shoot_fire(fire), .shot_ready(ready),
        .Player_HP(php), .NPC_HP(nhp),
        .Player_Dead(pdead), .NPC_Dead(ndead)
    );

    combat_controller #(.MAX_HP(15)) u_dut15 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .game_active(game_active), .Shoot_req(Shoot_req),
        .Proj_hit_npc(Proj_hit_npc), .Npc_hit_player(Npc_hit_player),
        .Shoot_fire(fire2), .shot_ready(ready2),
        .Player_HP(php2), .NPC_HP(nhp2),
        .Player_Dead(pdead2), .NPC_Dead(ndead2)
    );

    always #5 Clk = ~Clk;
    always #40 frame_clk = ~frame_clk;

`ifdef COMBAT_INVULN_EN
    localparam int HELD_HP = 70;
`else
    localparam int HELD_HP = 90;
`endif

    typedef struct {
        string name;
        int    php;
        int    nhp;
        int    pdead;
        int    ndead;
        int    rdy;
        int    nhp2;
    } snap_t;

    snap_t snap_q[$];
    int    fire_q[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic void cmp(input string nm, input string fld,
                                input int act, input int exp);
        if (exp < 0) return;
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, required %0d", nm, fld, act, exp);
        end
    endfunction

    always @(negedge Clk) begin : monitor
        snap_t s;
        int    e;
        if (fire) begin
            n_checks++;
            if (fire_q.size() == 0) begin
                n_fail++;
                $display("FAIL fire_unexpected: Shoot_fire=1 at cycle %0d, required 0", cyc);
            end else begin
                e = fire_q.pop_front();
                if (e != cyc) begin
                    n_fail++;
                    $display("FAIL fire_cycle: fired at cycle %0d, required %0d", cyc, e);
                end
            end
        end
        if (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            cmp(s.name, "Player_HP", int'(php), s.php);
            cmp(s.name, "NPC_HP", int'(nhp), s.nhp);
            cmp(s.name, "Player_Dead", int'(pdead), s.pdead);
            cmp(s.name, "NPC_Dead", int'(ndead), s.ndead);
            cmp(s.name, "shot_ready", int'(ready), s.rdy);
            cmp(s.name, "NPC_HP_15", int'(nhp2), s.nhp2);
        end
    end

    task automatic expect_snap(input string nm, input int a, input int b,
                               input int c, input int d, input int r,
                               input int n2);
        snap_t s;
        s.name = nm; s.php = a; s.nhp = b;
        s.pdead = c; s.ndead = d; s.rdy = r; s.nhp2 = n2;
        snap_q.push_back(s);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge frame_clk);
        step(4);
    endtask

    task automatic press(input bit expect_fire);
        Shoot_req = 1'b1;
        if (expect_fire) fire_q.push_back(cyc + 1);
        step(3);
        Shoot_req = 1'b0;
        step(1);
    endtask

    task automatic hit(input bit p, input bit n);
        Npc_hit_player = p;
        Proj_hit_npc   = n;
        step(1);
        Npc_hit_player = 1'b0;
        Proj_hit_npc   = 1'b0;
    endtask

    initial begin
        step(3);
        Reset = 1'b0;
        expect_snap("reset", 100, 100, 0, 0, 0, 15);
        step(1);

        game_active = 1'b1;
        step(1);
        expect_snap("arm", 100, 100, 0, 0, 1, 15);
        step(1);

        press(1'b1);
        expect_snap("cool_busy", 100, 100, 0, 0, 0, 15);
        step(1);
        wait_ticks(10);
        press(1'b0);
        expect_snap("cool_10", 100, 100, 0, 0, 0, 15);
        step(1);
        wait_ticks(25);
        expect_snap("cool_done", 100, 100, 0, 0, 1, 15);
        step(1);
        press(1'b1);

        for (int i = 1; i <= 10; i++) begin
            wait_ticks(22);
            hit(1'b0, 1'b1);
            expect_snap($sformatf("npc_hit%0d", i), 100, 100 - 10 * i,
                        0, 0, -1, (i == 1) ? 5 : 0);
            step(1);
        end
        expect_snap("npc_dead", 100, 0, 0, 1, 0, 0);
        step(1);

        press(1'b0);
        hit(1'b1, 1'b1);
        step(1);
        expect_snap("over_frozen", 100, 0, 0, 1, 0, 0);
        step(1);

        game_active = 1'b0;
        step(1);
        expect_snap("idle_clear", -1, -1, 0, 0, 0, -1);
        step(1);
        expect_snap("idle_reload", 100, 100, 0, 0, 0, 15);
        step(1);

        game_active = 1'b1;
        step(2);
        for (int i = 1; i <= 10; i++) begin
            wait_ticks(22);
            hit(1'b1, 1'b1);
            expect_snap($sformatf("both_hit%0d", i), 100 - 10 * i,
                        100 - 10 * i, 0, 0, -1, -1);
            step(1);
        end
        expect_snap("draw", 0, 0, 1, 1, 0, -1);
        step(1);

        game_active = 1'b0;
        step(2);
        game_active = 1'b1;
        step(2);
        Npc_hit_player = 1'b1;
        wait_ticks(45);
        Npc_hit_player = 1'b0;
        step(1);
        expect_snap("held_contact", HELD_HP, 100, 0, 0, -1, -1);
        step(1);

        Reset = 1'b1;
        step(1);
        expect_snap("mid_reset", 100, 100, 0, 0, 0, 15);
        Reset = 1'b0;
        step(1);
        expect_snap("rearm", 100, 100, 0, 0, 1, 15);
        step(5);

        n_checks++;
        if (fire_q.size() != 0) begin
            n_fail++;
            $display("FAIL fire_missing: %0d expected fires pending, required 0", fire_q.size());
        end
        n_checks++;
        if (snap_q.size() != 0) begin
            n_fail++;
            $display("FAIL snap_pending: %0d snapshots unchecked, required 0", snap_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/combat_controller.md
# combat_controller

Game-rule sequencer between the stage controller, the player projectile and the two fighters. It tracks both fighters' hit points, turns raw projectile/contact hits into damage, and enforces a per-frame shot cooldown on the player's fire button. It emits the Player_Dead/NPC_Dead flags that drive stage transitions, and the one-cycle fire pulse that launches the projectile.

## Interface
Parameters:
- HP_W, 7, width of each hit-point counter
- MAX_HP, 100, hit points loaded at game start (must be < 2^HP_W)
- HIT_DAMAGE, 10, hit points removed per accepted hit
- SHOT_COOLDOWN, 30, frames between accepted shots (1..255)
- INVULN_FRAMES, 20, post-hit invulnerability window in frames (1..255; used only with COMBAT_INVULN_EN)

Ports:
- Clk  in  1  system clock (CLOCK_50); one clock, all logic on its rising edge
- Reset  in  1  synchronous, active-high reset
- frame_clk  in  1  VGA_VS level; sampled in Clk
- game_active  in  1  stage controller is in game state (game_l)
- Shoot_req  in  1  fire button level, active-high
- Proj_hit_npc  in  1  projectile overlaps NPC (level)
- Npc_hit_player  in  1  NPC contact/attack overlaps player (level)
- Shoot_fire  out  1  one-cycle launch pulse to the projectile
- shot_ready  out  1  a shot would be accepted now
- Player_HP  out  HP_W  player hit points
- NPC_HP  out  HP_W  NPC hit points
- Player_Dead  out  1  Player_HP == 0 while in game
- NPC_Dead  out  1  NPC_HP == 0 while in game

## Operation
- Frame tick: frame_clk passes through a 2-flop synchronizer; tick = one-Clk-cycle pulse when the synchronized value goes 0->1.
- States: IDLE, ARMED, COOLDOWN, OVER.
- IDLE: HP registers held at MAX_HP, no firing, no damage. game_active=1 -> ARMED. HP is reloaded to MAX_HP on this transition.
- ARMED: a rising edge of Shoot_req (registered previous value) -> Shoot_fire=1 for the next cycle, cooldown counter = SHOT_COOLDOWN, -> COOLDOWN.
- COOLDOWN: counter decrements on each tick. Counter reaching 0 -> ARMED. A held Shoot_req does not refire; a new rising edge is required.
- Damage: an accepted hit sets HP <= (HP > HIT_DAMAGE) ? HP - HIT_DAMAGE : 0. The subtraction saturates and never wraps.
- Player and NPC damage are independent. Both may be applied in the same cycle.
- Any HP reaching 0 -> OVER the following cycle.
- OVER: HP frozen, no fire, no damage. Dead flags stay asserted.
- Both HP reaching 0 in the same cycle: both Dead flags assert (draw). The stage controller resolves the draw.
- game_active=0 in any state -> IDLE next cycle. Dead flags clear, the cooldown counter clears, and pending fire is dropped.
- shot_ready = (state == ARMED) && game_active.

## Timing
- Reset values: state IDLE; Player_HP = NPC_HP = MAX_HP; Shoot_fire, shot_ready, Player_Dead and NPC_Dead = 0; all counters 0.
- Shoot_req rising edge sampled at cycle N -> Shoot_fire high during cycle N+1 only.
- frame_clk rises before edge N -> tick at cycle N+2 or N+3 (synchronizer latency).
- Hit sampled at cycle N -> HP updated at N+1 -> Dead flag at N+2 -> OVER at N+2.
- Shoot edge and hit in the same cycle: both are honoured.
- Shoot edge in the cycle the counter expires: ignored, because the state is still COOLDOWN.
- Reset asserted mid-operation overrides everything on the next edge.

## Configuration
- COMBAT_INVULN_EN defined: each target has an invulnerability counter.
  - An accepted hit loads INVULN_FRAMES; the counter decrements on each tick.
  - A hit is accepted when the hit input is high and the counter is 0.
  - A held overlap therefore damages once per window.
- COMBAT_INVULN_EN undefined: a hit is accepted only on the rising edge of the hit input (registered previous value). A held overlap damages exactly once.

## Test plan
- Reset, then game_active=1: Player_HP = NPC_HP = 100, shot_ready=1, Dead flags 0.
- Shoot_req pulse: Shoot_fire is high exactly one cycle, shot_ready=0. A second press after 10 ticks gives no fire. A press after 30 ticks fires.
- 10 separated Proj_hit_npc pulses: NPC_HP steps 90..0. NPC_Dead=1 two cycles after the last hit. Further shots and hits are ignored.
- MAX_HP=15, HIT_DAMAGE=10, two hits: NPC_HP goes 5 then 0. The value saturates and never wraps.
- Player_HP and NPC_HP both at 10, both hit inputs raised in the same cycle: both HP go to 0 and both Dead flags assert.
- Npc_hit_player held high for 45 ticks: with COMBAT_INVULN_EN, Player_HP = 70 (hits at ticks 0, 20, 40); without it, Player_HP = 90.
